// File: rtl/program_loader.sv
// Loads a framed byte stream into instruction memory, verifies an XOR checksum,
// then releases the processor core from reset and starts it.
module program_loader #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned MAX_WORDS  = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_req,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic                  im_en_write,
    output logic [ADDR_WIDTH-1:0] im_address,
    output logic [DATA_WIDTH-1:0] im_data,
    output logic                  cpu_reset,
    output logic                  cpu_start,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int unsigned LEN_W  = 16;
    localparam int unsigned LEN_WX = LEN_W + 1;
    localparam logic [LEN_WX-1:0] MAX_N = LEN_WX'(MAX_WORDS);

    typedef enum logic [3:0] {
        IDLE,
        GET_LEN_HI,
        GET_LEN_LO,
        GET_HI,
        GET_LO,
        WRITE,
        GET_CHK,
        RELEASE,
        DONE,
        ERROR
    } state_t;

    state_t state;
    state_t state_d;

    logic [LEN_W-1:0]      len;
    logic [ADDR_WIDTH-1:0] index;
    logic [7:0]            word_hi;
    logic [7:0]            chk;

    logic             accept;
    logic             start;
    logic             last_word;
    logic             len_bad;
    logic [LEN_W-1:0] len_new;

    logic ready_d;
    logic write_d;
    logic busy_d;
    logic done_d;
    logic error_d;
    logic cpu_reset_d;
    logic cpu_start_d;

    // byte_ready is registered and high only in GET_* states, so accept implies one of them
    assign accept    = byte_valid & byte_ready;
    assign start     = load_req & ((state == IDLE) | (state == DONE) | (state == ERROR));
    assign len_new   = {len[LEN_W-1:8], byte_in};
    assign len_bad   = (len_new == '0) || ({1'b0, len_new} > MAX_N);
    assign last_word = (LEN_W'(index) == (len - LEN_W'(1)));

    // Next state, then outputs decoded from next state so they register alongside it
    always_comb begin
        state_d     = state;
        ready_d     = 1'b0;
        write_d     = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        error_d     = 1'b0;
        cpu_reset_d = 1'b1;
        cpu_start_d = 1'b0;

        case (state)
            IDLE, DONE, ERROR: if (start) state_d = GET_LEN_HI;
            GET_LEN_HI:        if (accept) state_d = GET_LEN_LO;
            GET_LEN_LO:        if (accept) state_d = len_bad ? ERROR : GET_HI;
            GET_HI:            if (accept) state_d = GET_LO;
            GET_LO:            if (accept) state_d = WRITE;
            WRITE:             state_d = last_word ? GET_CHK : GET_HI;
            GET_CHK:           if (accept) state_d = (byte_in == chk) ? RELEASE : ERROR;
            RELEASE:           state_d = DONE;
            default:           state_d = IDLE;
        endcase

        case (state_d)
            GET_LEN_HI, GET_LEN_LO, GET_HI, GET_LO, GET_CHK: begin
                ready_d = 1'b1;
                busy_d  = 1'b1;
            end
            WRITE: begin
                write_d = 1'b1;
                busy_d  = 1'b1;
            end
            RELEASE: busy_d = 1'b1;
            DONE: begin
                done_d      = 1'b1;
                cpu_reset_d = 1'b0;
                cpu_start_d = 1'b1;
            end
            ERROR:   error_d = 1'b1;
            default: busy_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            byte_ready  <= 1'b0;
            im_en_write <= 1'b0;
            im_address  <= '0;
            im_data     <= '0;
            cpu_reset   <= 1'b1;
            cpu_start   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            len         <= '0;
            index       <= '0;
            word_hi     <= '0;
            chk         <= '0;
        end else begin
            state       <= state_d;
            byte_ready  <= ready_d;
            im_en_write <= write_d;
            cpu_reset   <= cpu_reset_d;
            cpu_start   <= cpu_start_d;
            busy        <= busy_d;
            done        <= done_d;
            error       <= error_d;

            if (start) begin
                index <= '0;
                chk   <= '0;
            end

            // Datapath: length, word assembly and running checksum
            case (state)
                GET_LEN_HI: if (accept) begin
                    len[LEN_W-1:8] <= byte_in;
                    chk            <= chk ^ byte_in;
                end
                GET_LEN_LO: if (accept) begin
                    len[7:0] <= byte_in;
                    chk      <= chk ^ byte_in;
                end
                GET_HI: if (accept) begin
                    word_hi <= byte_in;
                    chk     <= chk ^ byte_in;
                end
                GET_LO: if (accept) begin
                    im_address <= index;
                    im_data    <= DATA_WIDTH'({word_hi, byte_in});
                    chk        <= chk ^ byte_in;
                end
                WRITE:   index <= index + ADDR_WIDTH'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboarded bench for program_loader: frames are driven byte by byte and every
// IM write is popped from an expectation queue and compared.
module tb_program_loader;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          load_req = 1'b0;
    logic [7:0]    byte_in = 8'h00;
    logic          byte_valid = 1'b0;
    logic          byte_ready;
    logic          im_en_write;
    logic [AW-1:0] im_address;
    logic [DW-1:0] im_data;
    logic          cpu_reset;
    logic          cpu_start;
    logic          busy;
    logic          done;
    logic          error;

    program_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WORDS(1024)) dut (
        .clk(clk), .reset(reset), .load_req(load_req), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .im_en_write(im_en_write),
        .im_address(im_address), .im_data(im_data), .cpu_reset(cpu_reset),
        .cpu_start(cpu_start), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t          exp_q[$];
    int           wr_cyc[$];
    logic [DW-1:0] frame_w[$];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           nwrites = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor and scoreboard
    always @(negedge clk) begin
        if (!reset && busy === 1'b1) begin
            checks++;
            if (cpu_reset !== 1'b1) begin
                errors++;
                $display("FAIL cpu_reset_while_busy got %b want 1 at cycle %0d", cpu_reset, cyc);
            end
        end
        if (im_en_write === 1'b1) begin
            wr_t e;
            nwrites++;
            wr_cyc.push_back(cyc);
            checks++;
            if (byte_ready !== 1'b0) begin
                errors++;
                $display("FAIL ready_in_write got %b want 0", byte_ready);
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write got addr %h data %h want none", im_address, im_data);
            end else begin
                e = exp_q.pop_front();
                if (im_address !== e.a || im_data !== e.d) begin
                    errors++;
                    $display("FAIL im_write got addr %h data %h want addr %h data %h",
                             im_address, im_data, e.a, e.d);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_load(output int lc);
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        lc = cyc;
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        bit ok = 1'b0;
        if (max_gap > 0) repeat ($urandom_range(0, max_gap)) tick();
        byte_in    = b;
        byte_valid = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (byte_ready === 1'b1) begin
                tick();
                ok = 1'b1;
            end
        end
        byte_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL byte_accept_timeout got none want byte %h accepted", b);
        end
    endtask

    // Drives the frame held in frame_w; optional bad checksum and a load_req poke before byte 'poke'
    task automatic send_frame(input int gap, input bit bad, input int poke);
        logic [7:0]  bytes[$];
        logic [7:0]  sum;
        logic [15:0] n;
        int          lc;
        n   = 16'(frame_w.size());
        sum = 8'h00;
        bytes.push_back(n[15:8]);
        bytes.push_back(n[7:0]);
        for (int i = 0; i < frame_w.size(); i++) begin
            logic [DW-1:0] w;
            w = frame_w[i];
            bytes.push_back(w[15:8]);
            bytes.push_back(w[7:0]);
            exp_q.push_back({AW'(i), w});
        end
        foreach (bytes[k]) sum = sum ^ bytes[k];
        if (bad) sum = sum ^ 8'h01;
        bytes.push_back(sum);
        for (int k = 0; k < bytes.size(); k++) begin
            if (k == poke) pulse_load(lc);
            send_byte(bytes[k], gap);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        checks++;
        if ({byte_ready, im_en_write, cpu_reset, cpu_start, busy, done, error} !== 7'b0010000
            || im_address !== '0 || im_data !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %b addr %h data %h want 0010000 addr 0 data 0",
                     {byte_ready, im_en_write, cpu_reset, cpu_start, busy, done, error},
                     im_address, im_data);
        end
        reset = 1'b0;
        tick();
        @(negedge clk);
        checks++;
        if ({byte_ready, im_en_write, cpu_reset, cpu_start, busy, done, error} !== 7'b0010000) begin
            errors++;
            $display("FAIL idle_after_reset got %b want 0010000",
                     {byte_ready, im_en_write, cpu_reset, cpu_start, busy, done, error});
        end
    endtask

    task automatic test_good_load();
        int lc;
        wr_cyc.delete();
        frame_w = '{16'h400A, 16'h7000};
        pulse_load(lc);
        send_frame(0, 1'b0, -1);
        @(negedge clk);
        checks++;
        if ({done, cpu_reset, busy, byte_ready} !== 4'b0110) begin
            errors++;
            $display("FAIL good_release got %b want 0110", {done, cpu_reset, busy, byte_ready});
        end
        @(negedge clk);
        checks++;
        if ({done, error, cpu_start, cpu_reset, busy, byte_ready} !== 6'b101000) begin
            errors++;
            $display("FAIL good_done got %b want 101000",
                     {done, error, cpu_start, cpu_reset, busy, byte_ready});
        end
        checks++;
        if (exp_q.size() != 0 || wr_cyc.size() != 2) begin
            errors++;
            $display("FAIL good_write_count got %0d pending %0d writes want 0 pending 2 writes",
                     exp_q.size(), wr_cyc.size());
            exp_q.delete();
        end else begin
            checks++;
            if (wr_cyc[0] - lc != 4 || wr_cyc[1] - wr_cyc[0] != 3) begin
                errors++;
                $display("FAIL write_latency got %0d,%0d want 4,3", wr_cyc[0] - lc, wr_cyc[1] - wr_cyc[0]);
            end
        end
    endtask

    task automatic test_bad_checksum();
        int lc;
        int w0;
        w0 = nwrites;
        frame_w = '{16'h400A, 16'h7000};
        pulse_load(lc);
        send_frame(0, 1'b1, -1);
        @(negedge clk);
        checks++;
        if ({done, error, cpu_start, cpu_reset, busy, byte_ready} !== 6'b010100) begin
            errors++;
            $display("FAIL bad_chk_state got %b want 010100",
                     {done, error, cpu_start, cpu_reset, busy, byte_ready});
        end
        checks++;
        if (nwrites - w0 != 2 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL bad_chk_writes got %0d pending %0d want 2 pending 0", nwrites - w0, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_zero_length();
        int lc;
        int w0;
        w0 = nwrites;
        pulse_load(lc);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        @(negedge clk);
        checks++;
        if ({error, done, byte_ready, cpu_reset, busy} !== 5'b10010) begin
            errors++;
            $display("FAIL zero_len_error got %b want 10010", {error, done, byte_ready, cpu_reset, busy});
        end
        byte_in    = 8'h55;
        byte_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (byte_ready !== 1'b0) begin
                errors++;
                $display("FAIL zero_len_ready got %b want 0", byte_ready);
            end
        end
        byte_valid = 1'b0;
        tick();
        checks++;
        if (nwrites != w0) begin
            errors++;
            $display("FAIL zero_len_writes got %0d want 0", nwrites - w0);
        end
    endtask

    task automatic test_backpressure();
        int lc;
        bit seen = 1'b0;
        frame_w = '{16'h400A, 16'h7000, 16'($urandom()), 16'($urandom())};
        pulse_load(lc);
        send_frame(3, 1'b0, -1);
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen || {error, cpu_start, cpu_reset, byte_ready} !== 4'b0100) begin
            errors++;
            $display("FAIL gaps_done got done %b flags %b want done 1 flags 0100",
                     done, {error, cpu_start, cpu_reset, byte_ready});
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL gaps_pending got %0d want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_mid_reset();
        int lc;
        pulse_load(lc);
        exp_q.push_back({AW'(0), 16'h1234});
        send_byte(8'h00, 0);
        send_byte(8'h03, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        @(negedge clk);
        #1;
        reset = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if ({byte_ready, im_en_write, cpu_reset, cpu_start, busy, done, error} !== 7'b0010000
            || im_address !== '0 || im_data !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs got %b addr %h data %h want 0010000 addr 0 data 0",
                     {byte_ready, im_en_write, cpu_reset, cpu_start, busy, done, error},
                     im_address, im_data);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL mid_reset_first_word got pending %0d want 0", exp_q.size());
            exp_q.delete();
        end
        reset = 1'b0;
        tick();
        frame_w = '{16'h0000};
        pulse_load(lc);
        send_frame(0, 1'b0, -1);
        repeat (2) @(negedge clk);
        checks++;
        if ({done, error, cpu_start, cpu_reset} !== 4'b1010 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL reload_done got %b pending %0d want 1010 pending 0",
                     {done, error, cpu_start, cpu_reset}, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_ignored_load();
        int lc;
        frame_w = '{16'hBEEF, 16'h0102, 16'hA5C3};
        pulse_load(lc);
        send_frame(1, 1'b0, 4);
        repeat (2) @(negedge clk);
        checks++;
        if ({done, error, cpu_start, cpu_reset, busy} !== 5'b10100 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL ignored_load got %b pending %0d want 10100 pending 0",
                     {done, error, cpu_start, cpu_reset, busy}, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_good_load();
        test_bad_checksum();
        test_zero_length();
        test_backpressure();
        test_mid_reset();
        test_ignored_load();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
